// File: rtl/rxrregif_cmd_asm_if.sv
// rxrregif_cmd_asm_if: FIFO read port and level/ack register bus for the command assembler.
// master = command assembler side, slave = FIFO/register-file side.
interface rxrregif_cmd_asm_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              fifo_rdempty;
  logic              fifo_rden;
  logic [7:0]        fifo_dataout;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic              reg_ack;
  logic [DATA_W-1:0] reg_rdata;
  modport master (
    input  fifo_rdempty, fifo_dataout, reg_ack, reg_rdata,
    output fifo_rden, reg_addr, reg_wdata, reg_wr, reg_rd
  );
  modport slave (
    output fifo_rdempty, fifo_dataout, reg_ack, reg_rdata,
    input  fifo_rden, reg_addr, reg_wdata, reg_wr, reg_rd
  );
endinterface

// File: rtl/rxrregif_cmd_asm.sv
// rxrregif_cmd_asm: pops FIFO bytes into opcode/address/data frames and issues one register access.
// Optional ack timeout enabled by defining RXRREGIF_TIMEOUT_EN.
module rxrregif_cmd_asm #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_,
  rxrregif_cmd_asm_if.master bus,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              cmd_err,
  output logic              busy,
  output logic              dbg
);
  localparam int AB = ADDR_W / 8;
  localparam int DB = DATA_W / 8;
  localparam int MB = AB > DB ? AB : DB;
  localparam int CW = $clog2(MB) + 1;
  localparam logic [CW-1:0] A_LAST = CW'(AB - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DB - 1);
  if (ADDR_W % 8 != 0 || DATA_W % 8 != 0 || ADDR_W < 8 || DATA_W < 8 || TO_CYCLES < 1) begin : g_bad_param
    $error("rxrregif_cmd_asm: widths must be non-zero multiples of 8 and TO_CYCLES >= 1");
  end
  typedef enum logic [2:0] {IDLE, FETCH, CAPT, ISSUE, WAIT_ACK} state_t;
  typedef enum logic [1:0] {F_OP, F_ADDR, F_DATA} fld_t;
  state_t            state_q, state_d;
  fld_t              fld_q, fld_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_rd_q, is_rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic              rd_valid_q, rd_valid_d, cmd_err_q, cmd_err_d;
  logic              op_ok, to_hit;
  assign op_ok = bus.fifo_dataout == 8'h01 || bus.fifo_dataout == 8'h02;
`ifdef RXRREGIF_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
  assign to_hit = to_q == TW'(TO_CYCLES - 1);
  assign to_d   = state_q == WAIT_ACK ? to_q + TW'(1) : '0;
  always_ff @(posedge clk or negedge reset_)
    if (!reset_) to_q <= '0;
    else         to_q <= to_d;
`else
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      fld_q      <= F_OP;
      cnt_q      <= '0;
      is_rd_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_data_q  <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fld_q      <= fld_d;
      cnt_q      <= cnt_d;
      is_rd_q    <= is_rd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_data_q  <= rd_data_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    fld_d      = fld_q;
    cnt_d      = cnt_q;
    is_rd_d    = is_rd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_data_d  = rd_data_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    rd_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    case (state_q)
      IDLE:  state_d = bus.fifo_rdempty ? IDLE : FETCH;
      FETCH: state_d = bus.fifo_rdempty ? FETCH : CAPT;
      CAPT: begin
        if (fld_q == F_OP) begin
          is_rd_d   = bus.fifo_dataout == 8'h02;
          fld_d     = F_ADDR;
          cmd_err_d = !op_ok;
          state_d   = op_ok ? FETCH : IDLE;
        end else if (fld_q == F_ADDR) begin
          addr_d  = ADDR_W'({addr_q, bus.fifo_dataout});
          cnt_d   = cnt_q == A_LAST ? '0 : cnt_q + CW'(1);
          fld_d   = cnt_q == A_LAST && !is_rd_q ? F_DATA : F_ADDR;
          state_d = cnt_q == A_LAST && is_rd_q ? ISSUE : FETCH;
        end else begin
          data_d  = DATA_W'({data_q, bus.fifo_dataout});
          cnt_d   = cnt_q + CW'(1);
          state_d = cnt_q == D_LAST ? ISSUE : FETCH;
        end
      end
      ISSUE: begin
        wr_d    = !is_rd_q;
        rd_d    = is_rd_q;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.reg_ack || to_hit) begin
          wr_d       = 1'b0;
          rd_d       = 1'b0;
          state_d    = IDLE;
          rd_valid_d = rd_q && bus.reg_ack;
          cmd_err_d  = !bus.reg_ack;
          rd_data_d  = rd_q && bus.reg_ack ? bus.reg_rdata : rd_data_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // every frame restarts from the opcode byte with a clean counter
    if (state_d == IDLE) begin
      cnt_d = '0;
      fld_d = F_OP;
    end
  end
  always_comb begin
    bus.fifo_rden = state_q == FETCH && !bus.fifo_rdempty;
    bus.reg_addr  = addr_q;
    bus.reg_wdata = data_q;
    bus.reg_wr    = wr_q;
    bus.reg_rd    = rd_q;
    rd_data       = rd_data_q;
    rd_valid      = rd_valid_q;
    cmd_err       = cmd_err_q;
    busy          = state_q != IDLE;
    dbg           = state_q == WAIT_ACK;
  end
endmodule
